queue_calc_param: RTL and testbench
===================================

Name: queue_calc_param

Overview:
- Parametrised successor to the team's fixed 8-bit/5-deep queue calculator.
- Holds a circular FIFO of WIDTH-bit operands and executes push, pop, arithmetic and clear commands.
- Binary ops consume the two oldest entries and append the result at the tail.
- Adds a multi-cycle iterative divider with a ready handshake, full/head/count visibility, coded sticky errors and a clear command; used as the arithmetic queue engine in the calculator datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- DEPTH, 8, queue capacity in entries (>=2)
- CNTW, $clog2(DEPTH+1), width of the count output (derived; do not override)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in  input  WIDTH  push operand
- op  input  3  command: 0 PUSH, 1 POP, 2 ADD, 3 MUL, 4 SUB, 5 DIV, 6 MOD, 7 CLR
- apply  input  1  command strobe; accepted on a rising edge only when ready=1
- ready  output  1  engine can accept a command
- tail  output  WIDTH  newest entry; 0 when empty
- head  output  WIDTH  oldest entry; 0 when empty
- count  output  CNTW  number of entries, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- valid  output  1  0 after an error (sticky)
- err_code  output  2  0 none, 1 overflow, 2 underflow, 3 divide-by-zero; holds the first error

Behaviour:
- Reset (rst=0, asynchronous): count=0, pointers=0, ready=1, valid=1, err_code=0, tail=head=0, empty=1, full=0. Any division in flight is aborted. Storage contents are don't-care.
- Storage: circular buffer. Pointers wrap DEPTH-1 -> 0 for any DEPTH, including non-powers of two.
- Operand order: a=head (oldest), b=entry after head.
- Arithmetic results, all modulo 2^WIDTH, unsigned:
  - ADD = a+b
  - MUL = low WIDTH bits of a*b
  - SUB = b-a (wraps)
  - DIV = b/a
  - MOD = b%a
- Binary op effect: head advances by 2, result is appended at the tail, net count -1. A binary op can never overflow.
- Single-cycle commands: PUSH, POP, ADD, SUB, MUL, CLR. Their effect is visible on outputs after the accepting edge; ready stays 1.
- DIV/MOD accepted with a!=0:
  - The accepting edge captures a and b; FSM moves IDLE -> BUSY; ready=0 from the next cycle.
  - Restoring division runs 1 quotient bit per cycle.
  - On the WIDTH-th edge after acceptance: result is written, pointers and count are updated, FSM returns to IDLE, ready=1.
  - Queue outputs are unchanged while BUSY.
- apply while ready=0 is ignored entirely (not buffered). in and op are don't-care while BUSY.
- Error checks, evaluated at acceptance; the queue is left unchanged on error:
  - PUSH with count==DEPTH -> err 1
  - POP with count==0 -> err 2
  - ADD..MOD with count<2 -> err 2
  - DIV/MOD with a==0 -> err 3; no BUSY cycles
- On error: valid<=0 and err_code is latched.
- While valid=0: all commands except CLR are accepted but have no effect; err_code keeps the first error.
- CLR: count<=0, pointers<=0, valid<=1, err_code<=0. CLR is legal in any state except BUSY.
- PUSH into an empty queue: head and tail both show the new entry.
- POP to empty: head=tail=0.

Test Plan:
- Push 3, push 4, ADD -> count=1, head=tail=7, ready never drops. Push 200, push 100, SUB -> tail=156. Then push 20, push 30, MUL -> tail=88.
- Push 5, push 17, MOD -> ready=0 for exactly 8 cycles, queue unchanged meanwhile, then tail=2, count=1. Repeat with DIV -> tail=3. An apply PUSH 9 pulsed while ready=0 is ignored; count is unaffected.
- Push 0, push 9, DIV -> same cycle valid=0, err_code=3, count=2, ready stays 1. Then PUSH 1 -> count still 2. Then CLR -> valid=1, err_code=0, count=0.
- Push 1..8 -> full=1, count=8, tail=8. Push 9 -> valid=0, err_code=1, tail=8. Then POP -> ignored, err_code remains 1.
- Empty queue: POP -> err_code=2. After CLR, push 6, ADD -> err_code=2, count=1.
- Wrap/reset: 20 rounds of push i, pop with DEPTH=5 -> head and tail always equal i, count alternates 1/0. Then start a MOD and pull rst low in cycle 3 of BUSY -> immediately ready=1, count=0, empty=1, valid=1. After release, the next command operates normally.

Source files
------------

// File: rtl/queue_calc_param.sv
// Circular-FIFO arithmetic engine: push/pop/clear plus binary ops on the two oldest
// entries, with a restoring divider that takes WIDTH cycles for DIV/MOD.
module queue_calc_param #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic             apply,
    output logic             ready,
    output logic [WIDTH-1:0] tail,
    output logic [WIDTH-1:0] head,
    output logic [CNTW-1:0]  count,
    output logic             empty,
    output logic             full,
    output logic             valid,
    output logic [1:0]       err_code
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ITW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_MUL = 3'd3,
                           OP_SUB  = 3'd4, OP_DIV = 3'd5, OP_MOD = 3'd6, OP_CLR = 3'd7;
    localparam logic [1:0] E_OVF = 2'd1, E_UNF = 2'd2, E_DBZ = 2'd3;

    typedef enum logic {IDLE, BUSY} state_e;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_e            state_q, state_d;
    logic [PW-1:0]     hd_q, hd_d, tl_q, tl_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [1:0]        err_q, err_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [ITW-1:0]    it_q, it_d;
    logic              mod_q, mod_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              wr_en;
    logic [PW-1:0]     wr_idx;
    logic [WIDTH-1:0]  wr_data;

    logic [PW-1:0]     hd1, hd2, last;
    logic [WIDTH-1:0]  opa, opb, res;
    logic [WIDTH:0]    rem_sh, rem_sub;
    logic              ge;
    logic [WIDTH-1:0]  rem_nx, dvd_nx;

    assign hd1  = inc(hd_q);
    assign hd2  = inc(hd1);
    assign last = (tl_q == '0) ? PW'(DEPTH - 1) : tl_q - PW'(1);
    assign opa  = mem_q[hd_q];
    assign opb  = mem_q[hd1];

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign ge      = (rem_sh >= {1'b0, dvs_q});
    assign rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign dvd_nx  = {dvd_q[WIDTH-2:0], ge};

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = opa + opb;
            OP_MUL:  res = opa * opb;
            OP_SUB:  res = opb - opa;
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hd_d    = hd_q;
        tl_d    = tl_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        it_d    = it_q;
        mod_d   = mod_q;
        wr_en   = 1'b0;
        wr_idx  = tl_q;
        wr_data = '0;
        if (state_q == BUSY) begin
            dvd_d = dvd_nx;
            rem_d = rem_nx;
            it_d  = it_q + ITW'(1);
            if (it_q == ITW'(WIDTH - 1)) begin
                wr_en   = 1'b1;
                wr_data = mod_q ? rem_nx : dvd_nx;
                hd_d    = hd2;
                tl_d    = inc(tl_q);
                cnt_d   = cnt_q - CNTW'(1);
                state_d = IDLE;
            end
        end else if (apply) begin
            if (op == OP_CLR) begin
                hd_d    = '0;
                tl_d    = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
                err_d   = '0;
            end else if (valid_q) begin
                case (op)
                    OP_PUSH: begin
                        if (cnt_q == CNTW'(DEPTH)) begin
                            valid_d = 1'b0;
                            err_d   = E_OVF;
                        end else begin
                            wr_en   = 1'b1;
                            wr_data = in;
                            tl_d    = inc(tl_q);
                            cnt_d   = cnt_q + CNTW'(1);
                        end
                    end
                    OP_POP: begin
                        if (cnt_q == '0) begin
                            valid_d = 1'b0;
                            err_d   = E_UNF;
                        end else begin
                            hd_d  = hd1;
                            cnt_d = cnt_q - CNTW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q < CNTW'(2)) begin
                            valid_d = 1'b0;
                            err_d   = E_UNF;
                        end else if (op == OP_DIV || op == OP_MOD) begin
                            if (opa == '0) begin
                                valid_d = 1'b0;
                                err_d   = E_DBZ;
                            end else begin
                                dvs_d   = opa;
                                dvd_d   = opb;
                                rem_d   = '0;
                                it_d    = '0;
                                mod_d   = (op == OP_MOD);
                                state_d = BUSY;
                            end
                        end else begin
                            wr_en   = 1'b1;
                            wr_data = res;
                            hd_d    = hd2;
                            tl_d    = inc(tl_q);
                            cnt_d   = cnt_q - CNTW'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hd_q    <= '0;
            tl_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            err_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            it_q    <= '0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hd_q    <= hd_d;
            tl_q    <= tl_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            it_q    <= it_d;
            mod_q   <= mod_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    assign ready    = (state_q == IDLE);
    assign count    = cnt_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNTW'(DEPTH));
    assign head     = empty ? '0 : mem_q[hd_q];
    assign tail     = empty ? '0 : mem_q[last];
    assign valid    = valid_q;
    assign err_code = err_q;
endmodule

// File: tb/tb_queue_calc_param.sv
// Randomized and directed bench for queue_calc_param against a queue-based reference model.
module tb_queue_calc_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din5;
    logic [2:0] op, op5;
    logic       apply, apply5;
    logic       ready, empty, full, valid;
    logic [7:0] tail, head;
    logic [3:0] count;
    logic [1:0] err_code;
    logic       ready5, empty5, full5, valid5;
    logic [7:0] tail5, head5;
    logic [2:0] count5;
    logic [1:0] err5;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue plus sticky status.
    logic [7:0] mq[$];
    bit         mv;
    logic [1:0] me;

    always #5 clk = ~clk;

    queue_calc_param #(.WIDTH(8), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .in(din), .op(op), .apply(apply), .ready(ready),
        .tail(tail), .head(head), .count(count), .empty(empty), .full(full),
        .valid(valid), .err_code(err_code));

    queue_calc_param #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .in(din5), .op(op5), .apply(apply5), .ready(ready5),
        .tail(tail5), .head(head5), .count(count5), .empty(empty5), .full(full5),
        .valid(valid5), .err_code(err5));

    task automatic m_err(input logic [1:0] e);
        mv = 0;
        me = e;
    endtask

    task automatic m_apply(input logic [2:0] o, input logic [7:0] v);
        int a, b, r;
        if (o == 3'd7) begin
            mq.delete();
            mv = 1;
            me = 0;
            return;
        end
        if (!mv) return;
        if (o == 3'd0) begin
            if (mq.size() == 8) m_err(2'd1); else mq.push_back(v);
        end else if (o == 3'd1) begin
            if (mq.size() == 0) m_err(2'd2); else void'(mq.pop_front());
        end else if (mq.size() < 2) begin
            m_err(2'd2);
        end else begin
            a = mq[0];
            b = mq[1];
            if ((o == 3'd5 || o == 3'd6) && a == 0) begin
                m_err(2'd3);
            end else begin
                case (o)
                    3'd2:    r = a + b;
                    3'd3:    r = a * b;
                    3'd4:    r = b - a + 256;
                    3'd5:    r = b / a;
                    default: r = b % a;
                endcase
                void'(mq.pop_front());
                void'(mq.pop_front());
                mq.push_back(8'(r % 256));
            end
        end
    endtask

    function automatic logic [7:0] m_head();
        return (mq.size() == 0) ? 8'd0 : mq[0];
    endfunction

    function automatic logic [7:0] m_tail();
        return (mq.size() == 0) ? 8'd0 : mq[mq.size() - 1];
    endfunction

    // Drive one command on the 8-deep engine; DIV/MOD also waits out the busy window.
    task automatic cmd(input logic [2:0] o, input logic [7:0] v);
        bit busy_exp;
        int n;
        busy_exp = (o == 3'd5 || o == 3'd6) && mv && mq.size() >= 2 && mq[0] != 0;
        op = o; din = v; apply = 1;
        @(posedge clk); #1;
        apply = 0;
        m_apply(o, v);
        if (busy_exp) begin
            n = 0;
            while (!ready && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n != 8) begin
                errors++;
                $display("FAIL div_latency got %0d cycles exp 8", n);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ready, empty, full, valid} !== 4'b1101) begin
            errors++;
            $display("FAIL reset_flags got %b exp 1101", {ready, empty, full, valid});
        end
        checks++;
        if (count !== 4'd0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_count got cnt=%0d err=%0d exp 0 0", count, err_code);
        end
        checks++;
        if (head !== 8'd0 || tail !== 8'd0) begin
            errors++;
            $display("FAIL reset_ht got %0d/%0d exp 0/0", head, tail);
        end
    endtask

    task automatic test_alu();
        bit dropped = 0;
        cmd(3'd7, 0); cmd(3'd0, 3); cmd(3'd0, 4);
        op = 3'd2; apply = 1;
        @(posedge clk); #1;
        apply = 0; m_apply(3'd2, 0);
        dropped = !ready;
        @(posedge clk); #1;
        dropped |= !ready;
        checks++;
        if (count !== 4'd1 || head !== 8'd7 || tail !== 8'd7 || dropped) begin
            errors++;
            $display("FAIL add got cnt=%0d h=%0d t=%0d drop=%0d exp 1 7 7 0", count, head, tail, dropped);
        end
        cmd(3'd7, 0); cmd(3'd0, 200); cmd(3'd0, 100); cmd(3'd4, 0);
        checks++;
        if (tail !== 8'd156 || count !== 4'd1) begin
            errors++;
            $display("FAIL sub got t=%0d cnt=%0d exp 156 1", tail, count);
        end
        cmd(3'd7, 0); cmd(3'd0, 20); cmd(3'd0, 30); cmd(3'd3, 0);
        checks++;
        if (tail !== 8'd88 || head !== 8'd88) begin
            errors++;
            $display("FAIL mul got t=%0d h=%0d exp 88 88", tail, head);
        end
    endtask

    task automatic test_div(input logic [2:0] o, input logic [7:0] exp_r);
        int n;
        bit moved;
        cmd(3'd7, 0); cmd(3'd0, 5); cmd(3'd0, 17);
        op = o; apply = 1;
        @(posedge clk); #1;
        apply = 0; m_apply(o, 0);
        n = 0; moved = 0;
        while (!ready && n < 40) begin
            if (count !== 4'd2 || head !== 8'd5 || tail !== 8'd17) moved = 1;
            // A push strobed mid-division must be dropped.
            if (n == 2) begin op = 3'd0; din = 9; apply = 1; end
            @(posedge clk); #1;
            apply = 0;
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL divbusy op%0d got %0d cycles exp 8", o, n);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL divhold op%0d got queue change exp none", o);
        end
        checks++;
        if (tail !== exp_r || count !== 4'd1) begin
            errors++;
            $display("FAIL divres op%0d got t=%0d cnt=%0d exp %0d 1", o, tail, count, exp_r);
        end
    endtask

    task automatic test_div0();
        cmd(3'd7, 0); cmd(3'd0, 0); cmd(3'd0, 9); cmd(3'd5, 0);
        checks++;
        if (valid !== 1'b0 || err_code !== 2'd3 || count !== 4'd2 || ready !== 1'b1) begin
            errors++;
            $display("FAIL div0 got v=%0d e=%0d cnt=%0d rdy=%0d exp 0 3 2 1", valid, err_code, count, ready);
        end
        cmd(3'd0, 1);
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL div0_push got cnt=%0d exp 2", count);
        end
        cmd(3'd7, 0);
        checks++;
        if (valid !== 1'b1 || err_code !== 2'd0 || count !== 4'd0) begin
            errors++;
            $display("FAIL clr got v=%0d e=%0d cnt=%0d exp 1 0 0", valid, err_code, count);
        end
    endtask

    task automatic test_full();
        cmd(3'd7, 0);
        for (int i = 1; i <= 8; i++) cmd(3'd0, 8'(i));
        checks++;
        if (full !== 1'b1 || count !== 4'd8 || tail !== 8'd8 || head !== 8'd1) begin
            errors++;
            $display("FAIL full got f=%0d cnt=%0d t=%0d h=%0d exp 1 8 8 1", full, count, tail, head);
        end
        cmd(3'd0, 9);
        checks++;
        if (valid !== 1'b0 || err_code !== 2'd1 || tail !== 8'd8) begin
            errors++;
            $display("FAIL ovf got v=%0d e=%0d t=%0d exp 0 1 8", valid, err_code, tail);
        end
        cmd(3'd1, 0);
        checks++;
        if (err_code !== 2'd1 || count !== 4'd8) begin
            errors++;
            $display("FAIL ovf_pop got e=%0d cnt=%0d exp 1 8", err_code, count);
        end
    endtask

    task automatic test_underflow();
        cmd(3'd7, 0); cmd(3'd1, 0);
        checks++;
        if (err_code !== 2'd2 || valid !== 1'b0) begin
            errors++;
            $display("FAIL unf_pop got e=%0d v=%0d exp 2 0", err_code, valid);
        end
        cmd(3'd7, 0); cmd(3'd0, 6); cmd(3'd2, 0);
        checks++;
        if (err_code !== 2'd2 || count !== 4'd1 || head !== 8'd6) begin
            errors++;
            $display("FAIL unf_add got e=%0d cnt=%0d h=%0d exp 2 1 6", err_code, count, head);
        end
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [7:0] v;
        int r;
        cmd(3'd7, 0);
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 99);
            if      (r < 35) o = 3'd0;
            else if (r < 48) o = 3'd1;
            else if (r < 58) o = 3'd2;
            else if (r < 66) o = 3'd3;
            else if (r < 74) o = 3'd4;
            else if (r < 83) o = 3'd5;
            else if (r < 92) o = 3'd6;
            else             o = 3'd7;
            if (!mv && $urandom_range(0, 3) == 0) o = 3'd7;
            v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            cmd(o, v);
            checks++;
            if (count !== 4'(mq.size()) || head !== m_head() || tail !== m_tail()) begin
                errors++;
                $display("FAIL rnd_queue step %0d op %0d got cnt=%0d h=%0d t=%0d exp %0d %0d %0d",
                         s, o, count, head, tail, mq.size(), m_head(), m_tail());
            end
            checks++;
            if (valid !== mv || err_code !== me || ready !== 1'b1 ||
                full !== (mq.size() == 8) || empty !== (mq.size() == 0)) begin
                errors++;
                $display("FAIL rnd_status step %0d got v=%0d e=%0d r=%0d f=%0d em=%0d exp v=%0d e=%0d",
                         s, valid, err_code, ready, full, empty, mv, me);
            end
        end
    endtask

    task automatic test_wrap_reset();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            op5 = 3'd0; din5 = 8'(i); apply5 = 1;
            @(posedge clk); #1;
            if (head5 !== 8'(i) || tail5 !== 8'(i) || count5 !== 3'd1) bad++;
            op5 = 3'd1;
            @(posedge clk); #1;
            apply5 = 0;
            if (head5 !== 8'd0 || tail5 !== 8'd0 || count5 !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap got %0d bad samples exp 0", bad);
        end
        op5 = 3'd0; din5 = 5; apply5 = 1;
        @(posedge clk); #1;
        din5 = 17;
        @(posedge clk); #1;
        op5 = 3'd6;
        @(posedge clk); #1;
        apply5 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ready5 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_busy got rdy=%0d exp 0", ready5);
        end
        #2 rst = 0;
        #1;
        mq.delete(); mv = 1; me = 0;
        checks++;
        if (ready5 !== 1'b1 || count5 !== 3'd0 || empty5 !== 1'b1 || valid5 !== 1'b1) begin
            errors++;
            $display("FAIL abort got rdy=%0d cnt=%0d em=%0d v=%0d exp 1 0 1 1", ready5, count5, empty5, valid5);
        end
        #2 rst = 1;
        @(posedge clk); #1;
        op5 = 3'd0; din5 = 4; apply5 = 1;
        @(posedge clk); #1;
        apply5 = 0;
        checks++;
        if (count5 !== 3'd1 || head5 !== 8'd4 || err5 !== 2'd0) begin
            errors++;
            $display("FAIL post_rst got cnt=%0d h=%0d e=%0d exp 1 4 0", count5, head5, err5);
        end
    endtask

    initial begin
        rst = 0; apply = 0; apply5 = 0; op = 0; op5 = 0; din = 0; din5 = 0;
        mv = 1; me = 0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1;
        @(posedge clk); #1;
        test_reset();
        test_alu();
        test_div(3'd6, 8'd2);
        test_div(3'd5, 8'd3);
        test_div0();
        test_full();
        test_underflow();
        test_random();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
